// File: rtl/motion_pkg.sv
// motion_pkg
//   Shared definitions for the motion / adaptive-threshold pipeline.
//   - Frame geometry: 320x240 frame of 4-bit pixels, packed 4 per 16-bit word
//     (80 words per row). The frame is also viewed as 80x60 blocks of 4x4 pixels.
//   - Min-max buffer entry layout: max in [7:4], min in [3:0]. The threshold
//     stage reads entries in this same layout.
//   - FSM state type for block_minmax_builder.
package motion_pkg;

  localparam int FRAME_W      = 320;
  localparam int FRAME_H      = 240;
  localparam int PIX_W        = 4;
  localparam int PIX_PER_WORD = 4;
  localparam int H_WORDS      = 80;   // words per row == blocks across
  localparam int V_BLOCKS     = 60;   // blocks down
  localparam int BLK_ROWS     = 4;    // pixel rows per block
  localparam int MM_DEPTH     = 4800; // H_WORDS * V_BLOCKS

  localparam int FB_ADDR_W = 15;
  localparam int MM_ADDR_W = 13;
  localparam int BX_W      = 7;
  localparam int BY_W      = 6;

  localparam logic [BX_W-1:0] BX_LAST = BX_W'(H_WORDS - 1);
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(V_BLOCKS - 1);

  // Step between the rows of one block inside the frame buffer.
  localparam logic [FB_ADDR_W-1:0] FB_ROW_STEP = FB_ADDR_W'(H_WORDS);
  // Top-left word of block (0,by+1) relative to block (79,by):
  // -79 columns, +4 rows of 80 words => +241.
  localparam logic [FB_ADDR_W-1:0] FB_BAND_STEP =
    FB_ADDR_W'(BLK_ROWS * H_WORDS - (H_WORDS - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2,
    WR    = 2'd3
  } bmm_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix_max;
    logic [PIX_W-1:0] pix_min;
  } mm_entry_t;

  function automatic mm_entry_t mm_pack(input logic [PIX_W-1:0] mx,
                                        input logic [PIX_W-1:0] mn);
    mm_entry_t e;
    e.pix_max = mx;
    e.pix_min = mn;
    return e;
  endfunction

endpackage

// File: rtl/block_minmax_builder_nibble_minmax4.sv
// nibble_minmax4
//   Combinational reduction of one packed frame word to the maximum and
//   minimum of its four unsigned 4-bit pixels.
// Ports
//   data_word in  16  four pixels, nibble k = bits [4k+3:4k]
//   wmax      out 4   largest nibble
//   wmin      out 4   smallest nibble
module nibble_minmax4
  import motion_pkg::*;
(
  input  logic [15:0]      data_word,
  output logic [PIX_W-1:0] wmax,
  output logic [PIX_W-1:0] wmin
);

  logic [PIX_W-1:0] nib  [PIX_PER_WORD];
  logic [PIX_W-1:0] pmax [2];
  logic [PIX_W-1:0] pmin [2];

  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_nib
      assign nib[gi] = data_word[gi*PIX_W +: PIX_W];
    end
    // Two-level compare tree: pairs (0,1) and (2,3), then the pair results.
    for (gi = 0; gi < 2; gi++) begin : g_pair
      assign pmax[gi] = (nib[2*gi] > nib[2*gi+1]) ? nib[2*gi] : nib[2*gi+1];
      assign pmin[gi] = (nib[2*gi] < nib[2*gi+1]) ? nib[2*gi] : nib[2*gi+1];
    end
  endgenerate

  assign wmax = (pmax[0] > pmax[1]) ? pmax[0] : pmax[1];
  assign wmin = (pmin[0] < pmin[1]) ? pmin[0] : pmin[1];

endmodule

// File: rtl/block_minmax_builder.sv
// block_minmax_builder
//   Scans the packed 320x240 frame buffer block by block (4x4 pixels, one
//   frame word wide) and writes {max,min} of every block into the 80x60
//   min-max buffer. One full pass per start request; 6 cycles per block
//   (4 reads, 1 drain for the last read's data, 1 write).
//   Build option: BMM_CONTINUOUS_EN -- when defined, the block restarts a
//   new pass by itself after each pass (IDLE lasts one cycle) and ignores
//   start. Undefined: waits in IDLE for start.
// Ports
//   clk      in  1   clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   start    in  1   pass request, sampled only in IDLE
//   busy     out 1   high from the first read cycle through the last write cycle
//   done     out 1   one-cycle pulse after the last block is written
//   fb_en    out 1   frame buffer read enable
//   fb_addr  out 15  frame buffer word address
//   fb_data  in  16  frame buffer read data, valid one cycle after fb_en
//   mm_we    out 1   min-max buffer write enable
//   mm_addr  out 13  min-max buffer address (80*by + bx)
//   mm_din   out 8   {max[3:0], min[3:0]}
module block_minmax_builder
  import motion_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fb_en,
  output logic [FB_ADDR_W-1:0] fb_addr,
  input  logic [15:0]          fb_data,
  output logic                 mm_we,
  output logic [MM_ADDR_W-1:0] mm_addr,
  output logic [7:0]           mm_din
);

  bmm_state_t state_reg, state_next;

  logic [BX_W-1:0]      bx_reg, bx_next;
  logic [BY_W-1:0]      by_reg, by_next;
  logic [1:0]           r_reg, r_next;
  // Running top-left word address of the current block (320*by + bx) and
  // running block index (80*by + bx); both avoid multipliers.
  logic [FB_ADDR_W-1:0] base_reg, base_next;
  logic [MM_ADDR_W-1:0] blk_reg, blk_next;
  logic [PIX_W-1:0]     acc_max_reg, acc_max_next;
  logic [PIX_W-1:0]     acc_min_reg, acc_min_next;

  // All outputs are registered so they are glitch-free and land in the
  // same cycle as the state they belong to.
  logic                 fb_en_reg, fb_en_next;
  logic [FB_ADDR_W-1:0] fb_addr_reg, fb_addr_next;
  logic                 mm_we_reg, mm_we_next;
  logic [MM_ADDR_W-1:0] mm_addr_reg, mm_addr_next;
  mm_entry_t            mm_din_reg, mm_din_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  logic             go;
  logic [PIX_W-1:0] w_max, w_min;
  logic [PIX_W-1:0] fold_max, fold_min;

`ifdef BMM_CONTINUOUS_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  nibble_minmax4 u_word_minmax (
    .data_word (fb_data),
    .wmax      (w_max),
    .wmin      (w_min)
  );

  assign fold_max = (w_max > acc_max_reg) ? w_max : acc_max_reg;
  assign fold_min = (w_min < acc_min_reg) ? w_min : acc_min_reg;

  always_comb begin
    state_next   = state_reg;
    bx_next      = bx_reg;
    by_next      = by_reg;
    r_next       = r_reg;
    base_next    = base_reg;
    blk_next     = blk_reg;
    acc_max_next = acc_max_reg;
    acc_min_next = acc_min_reg;
    fb_en_next   = 1'b0;
    fb_addr_next = fb_addr_reg;
    mm_we_next   = 1'b0;
    mm_addr_next = mm_addr_reg;
    mm_din_next  = mm_din_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next   = RD;
          r_next       = 2'd0;
          bx_next      = '0;
          by_next      = '0;
          base_next    = '0;
          blk_next     = '0;
          fb_en_next   = 1'b1;
          fb_addr_next = '0;
        end
      end

      RD: begin
        // Data on fb_data belongs to the read issued last cycle (row r-1).
        // Row 0 data arrives at r=1 and seeds the accumulators.
        if (r_reg == 2'd1) begin
          acc_max_next = w_max;
          acc_min_next = w_min;
        end else if (r_reg != 2'd0) begin
          acc_max_next = fold_max;
          acc_min_next = fold_min;
        end

        if (r_reg == 2'd3) begin
          state_next = DRAIN;
        end else begin
          r_next       = r_reg + 2'd1;
          fb_en_next   = 1'b1;
          fb_addr_next = fb_addr_reg + FB_ROW_STEP;
        end
      end

      DRAIN: begin
        // Row 3 data is folded straight into the outgoing entry.
        acc_max_next = fold_max;
        acc_min_next = fold_min;
        state_next   = WR;
        mm_we_next   = 1'b1;
        mm_addr_next = blk_reg;
        mm_din_next  = mm_pack(fold_max, fold_min);
      end

      WR: begin
        r_next = 2'd0;
        if (bx_reg < BX_LAST) begin
          bx_next      = bx_reg + 1'b1;
          base_next    = base_reg + 1'b1;
          blk_next     = blk_reg + 1'b1;
          state_next   = RD;
          fb_en_next   = 1'b1;
          fb_addr_next = base_reg + 1'b1;
        end else begin
          bx_next = '0;
          if (by_reg < BY_LAST) begin
            by_next      = by_reg + 1'b1;
            base_next    = base_reg + FB_BAND_STEP;
            blk_next     = blk_reg + 1'b1;
            state_next   = RD;
            fb_en_next   = 1'b1;
            fb_addr_next = base_reg + FB_BAND_STEP;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bx_reg      <= '0;
      by_reg      <= '0;
      r_reg       <= '0;
      base_reg    <= '0;
      blk_reg     <= '0;
      acc_max_reg <= '0;
      acc_min_reg <= '0;
      fb_en_reg   <= 1'b0;
      fb_addr_reg <= '0;
      mm_we_reg   <= 1'b0;
      mm_addr_reg <= '0;
      mm_din_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bx_reg      <= bx_next;
      by_reg      <= by_next;
      r_reg       <= r_next;
      base_reg    <= base_next;
      blk_reg     <= blk_next;
      acc_max_reg <= acc_max_next;
      acc_min_reg <= acc_min_next;
      fb_en_reg   <= fb_en_next;
      fb_addr_reg <= fb_addr_next;
      mm_we_reg   <= mm_we_next;
      mm_addr_reg <= mm_addr_next;
      mm_din_reg  <= mm_din_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign fb_en   = fb_en_reg;
  assign fb_addr = fb_addr_reg;
  assign mm_we   = mm_we_reg;
  assign mm_addr = mm_addr_reg;
  assign mm_din  = mm_din_reg;

endmodule

// File: tb/tb_block_minmax_builder.sv
// tb_block_minmax_builder
//   Frame buffer model with one-cycle read latency, min-max buffer capture,
//   and a scoreboard of expected {mm_addr, mm_din} writes built from the
//   frame contents before each pass.
module tb_block_minmax_builder;

  localparam int NW       = 19200;
  localparam int NBLK     = 4800;
  localparam int PASS_CYC = 28800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, fb_en, mm_we;
  logic [14:0] fb_addr;
  logic [15:0] fb_data;
  logic [12:0] mm_addr;
  logic [7:0]  mm_din;

  block_minmax_builder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .fb_en   (fb_en),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .mm_we   (mm_we),
    .mm_addr (mm_addr),
    .mm_din  (mm_din)
  );

  always #5 clk = ~clk;

  logic [15:0] frame  [NW];
  logic [7:0]  mm_mem [NBLK];
  logic [20:0] exp_q  [$];

  int n_checks = 0;
  int n_err    = 0;
  int edge_cnt = 0;
  int t0       = 0;
  int n_wr     = 0;
  int n_done   = 0;
  int last_mm  = -1;
  int last_fb  [4];
  bit sb_on    = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (fb_en) fb_data <= (int'(fb_addr) < NW) ? frame[fb_addr] : 16'hDEAD;
  end

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (fb_en) begin
      for (int i = 0; i < 3; i++) last_fb[i] = last_fb[i+1];
      last_fb[3] = int'(fb_addr);
    end
    if (done) n_done++;
    if (mm_we) begin
      n_wr++;
      last_mm = int'(mm_addr);
      if (int'(mm_addr) < NBLK) mm_mem[mm_addr] = mm_din;
      if (sb_on) begin
        if (exp_q.size() == 0) check("mm_extra_write", 1, 0);
        else check("mm_write", {mm_addr, mm_din}, exp_q.pop_front());
      end
    end
  end

  // Reference: direct spatial scan of the 16 pixels of block (bx,by).
  function automatic logic [7:0] blk_exp(input int bx, input int by);
    logic [3:0]  mx, mn, p;
    logic [15:0] w;
    mx = 4'h0;
    mn = 4'hF;
    for (int y = 4*by; y < 4*by + 4; y++) begin
      for (int x = 4*bx; x < 4*bx + 4; x++) begin
        w = frame[y*80 + x/4];
        p = w[(x%4)*4 +: 4];
        if (p > mx) mx = p;
        if (p < mn) mn = p;
      end
    end
    return {mx, mn};
  endfunction

  task automatic push_expected();
    logic [12:0] a;
    exp_q.delete();
    for (int by = 0; by < 60; by++)
      for (int bx = 0; bx < 80; bx++) begin
        a = 13'(80*by + bx);
        exp_q.push_back({a, blk_exp(bx, by)});
      end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < NW; i++) frame[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NW; i++) frame[i] = 16'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {busy, done, fb_en, mm_we, fb_addr, mm_addr, mm_din}, 40'h0);
  endtask

  // One full pass from a start pulse; optional stray start pulses mid-pass.
  task automatic run_pass(input string name, input bit inject);
    int c;
    int done_c;
    push_expected();
    n_wr   = 0;
    n_done = 0;
    done_c = -1;
    @(negedge clk);
    start = 1'b1;
    t0 = edge_cnt;
    c = 0;
    while (done_c < 0 && c < PASS_CYC + 200) begin
      @(negedge clk);
      c = edge_cnt - t0;
      start = inject && (c == 5 || c == 20000);
      if (c == 1) check({name, "_busy_c1"}, busy, 1'b1);
      if (done) done_c = c;
    end
    start = 1'b0;
    if (done_c < 0) check({name, "_done_timeout"}, 0, 1);
    else check({name, "_done_cycle"}, done_c, PASS_CYC + 1);
    check({name, "_wr_count"}, n_wr, NBLK);
    check({name, "_queue_left"}, exp_q.size(), 0);
    repeat (10) @(negedge clk);
    check({name, "_done_count"}, n_done, 1);
    check({name, "_idle_busy"}, busy, 1'b0);
    $display("pass %s: done_cycle=%0d writes=%0d dones=%0d", name, done_c, n_wr, n_done);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fb_data = '0;
    for (int i = 0; i < 4; i++) last_fb[i] = -1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");

`ifdef BMM_CONTINUOUS_EN
    begin
      int c;
      int done_c;
      bit restarted;
      fill(16'h5555);
      push_expected();
      n_wr = 0;
      done_c = -1;
      rst_n = 1'b1;
      t0 = edge_cnt;
      c = 0;
      while (done_c < 0 && c < PASS_CYC + 200) begin
        @(negedge clk);
        c = edge_cnt - t0;
        if (done) done_c = c;
      end
      sb_on = 1'b0;
      check("cont_done_cycle", done_c, PASS_CYC + 1);
      check("cont_wr_count", n_wr, NBLK);
      restarted = 1'b0;
      for (int i = 0; i < 2 && !restarted; i++) begin
        @(negedge clk);
        if (fb_en) restarted = 1'b1;
      end
      check("cont_restart", restarted, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("cont_reset_outputs");
      $display("continuous: done_cycle=%0d restarted=%0d", done_c, restarted);
    end
`else
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_busy", busy, 1'b0);

    // Uniform frame.
    fill(16'h5555);
    run_pass("uniform", 1'b0);
    check("uniform_mm0", mm_mem[0], 8'h55);

    // One block with the full 0..F range.
    fill(16'h7777);
    frame[8*80 + 3]  = 16'h0123;
    frame[9*80 + 3]  = 16'h4567;
    frame[10*80 + 3] = 16'h89AB;
    frame[11*80 + 3] = 16'hCDEF;
    run_pass("block_3_2", 1'b0);
    check("mm163", mm_mem[163], 8'hF0);
    check("mm162", mm_mem[162], 8'h77);

    // Last block addressing and a single dark pixel.
    fill(16'hAAAA);
    frame[19199] = 16'hA1AA;
    run_pass("last_block", 1'b0);
    check("fb_last0", last_fb[0], 18959);
    check("fb_last1", last_fb[1], 19039);
    check("fb_last2", last_fb[2], 19119);
    check("fb_last3", last_fb[3], 19199);
    check("mm_last_addr", last_mm, 4799);
    check("mm4799", mm_mem[4799], 8'hA1);

    // Abort mid-pass by reset, then a clean pass.
    begin
      int c;
      fill_rand();
      push_expected();
      n_done = 0;
      @(negedge clk);
      start = 1'b1;
      t0 = edge_cnt;
      c = 0;
      while (c < 10000) begin
        @(negedge clk);
        c = edge_cnt - t0;
        start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort_outputs");
      @(negedge clk);
      check_reset_outputs("abort_outputs_hold");
      check("abort_no_done", n_done, 0);
      exp_q.delete();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_idle", busy, 1'b0);
      $display("abort: reset at cycle %0d dones=%0d", c, n_done);
    end
    fill_rand();
    run_pass("after_abort", 1'b0);

    // Stray start pulses during a pass are ignored.
    fill_rand();
    run_pass("stray_start", 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
